// File: rtl/sram2sraml_bridge_if.sv
// SRAM-like bus between the bridge (master) and the core bus (slave).
// The master holds one request at a time and waits for data_ok before issuing the next.
interface sram2sraml_bridge_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram2sraml_bridge.sv
// Converts single-cycle SRAM accesses into an addr_ok/data_ok transaction.
// The pipeline is stalled until the access completes; the result is held while the global stall is active.
module sram2sraml_bridge #(
    parameter int ADDR_W         = 32,
    parameter int WRITE_SUPPORT  = 1,
    parameter int READ_FULL_WORD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sram_en,
    input  logic [3:0]        sram_wen,
    input  logic [3:0]        sram_ben,
    input  logic [ADDR_W-1:0] sram_addr,
    input  logic [31:0]       sram_wdata,
    output logic [31:0]       sram_rdata,
    output logic              stall,
    input  logic              all_stall,
    output logic              err,
    sram2sraml_bridge_if.master bus
);
    typedef enum logic [1:0] {IDLE, DATA, DONE} state_t;

    localparam bit WR_EN   = (WRITE_SUPPORT != 0);
    localparam bit FULL_RD = (READ_FULL_WORD != 0);

    state_t      state;
    logic [31:0] hold;
    logic        is_wr;
    logic [3:0]  mask;
    logic [1:0]  size;
    logic [1:0]  off;
    logic        bad;
    logic        resp;

    always_comb begin
        is_wr = WR_EN && (sram_wen != 4'b0000);
        mask  = 4'b1111;
        if (is_wr)
            mask = sram_wen;
        else if (!FULL_RD)
            mask = (sram_ben == 4'b0000) ? 4'b1111 : sram_ben;

        size = 2'd2;
        off  = 2'b00;
        bad  = 1'b0;
        case (mask)
            4'b0001: begin size = 2'd0; off = 2'b00; end
            4'b0010: begin size = 2'd0; off = 2'b01; end
            4'b0100: begin size = 2'd0; off = 2'b10; end
            4'b1000: begin size = 2'd0; off = 2'b11; end
            4'b0011: begin size = 2'd1; off = 2'b00; end
            4'b1100: begin size = 2'd1; off = 2'b10; end
            4'b1111: begin size = 2'd2; off = 2'b00; end
            default: bad = 1'b1;
        endcase
    end

    // Response only counts while a transaction is outstanding.
    assign resp = (state == DATA) && bus.data_ok;

    assign bus.req   = rst && (state == IDLE) && sram_en;
    assign bus.wr    = is_wr;
    assign bus.size  = size;
    assign bus.addr  = {sram_addr[ADDR_W-1:2], off};
    assign bus.wdata = WR_EN ? sram_wdata : 32'h0;

    assign err        = bus.req && bus.addr_ok && bad;
    assign stall      = rst && sram_en && ((state == IDLE) || ((state == DATA) && !bus.data_ok));
    assign sram_rdata = !rst ? 32'h0 : (resp ? bus.rdata : hold);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            hold  <= 32'h0;
        end else begin
            case (state)
                IDLE: if (bus.req && bus.addr_ok) state <= DATA;
                DATA: if (bus.data_ok) state <= all_stall ? DONE : IDLE;
                DONE: if (!all_stall) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (resp)
                hold <= bus.rdata;
        end
    end
endmodule

// File: tb/tb_sram2sraml_bridge.sv
// Directed bench: default bridge, a ben-sized read port and a read-only port share one stimulus.
module tb_sram2sraml_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [3:0]  sram_ben;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        all_stall;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    logic [31:0] rd0, rd1, rd2;
    logic        st0, st1, st2;
    logic        er0, er1, er2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram2sraml_bridge_if bus0 ();
    sram2sraml_bridge_if bus1 ();
    sram2sraml_bridge_if bus2 ();

    assign bus0.addr_ok = addr_ok;
    assign bus0.data_ok = data_ok;
    assign bus0.rdata   = rdata;
    assign bus1.addr_ok = addr_ok;
    assign bus1.data_ok = data_ok;
    assign bus1.rdata   = rdata;
    assign bus2.addr_ok = addr_ok;
    assign bus2.data_ok = data_ok;
    assign bus2.rdata   = rdata;

    sram2sraml_bridge u_dut (
        .clk(clk), .rst(rst), .sram_en(sram_en), .sram_wen(sram_wen), .sram_ben(sram_ben),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(rd0), .stall(st0),
        .all_stall(all_stall), .err(er0), .bus(bus0)
    );

    sram2sraml_bridge #(.READ_FULL_WORD(0)) u_ben (
        .clk(clk), .rst(rst), .sram_en(sram_en), .sram_wen(sram_wen), .sram_ben(sram_ben),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(rd1), .stall(st1),
        .all_stall(all_stall), .err(er1), .bus(bus1)
    );

    sram2sraml_bridge #(.WRITE_SUPPORT(0)) u_ro (
        .clk(clk), .rst(rst), .sram_en(sram_en), .sram_wen(sram_wen), .sram_ben(sram_ben),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(rd2), .stall(st2),
        .all_stall(all_stall), .err(er2), .bus(bus2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        sram_en   = 1'b0;
        sram_wen  = 4'b0000;
        sram_ben  = 4'b0000;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        rdata     = 32'h0;
        all_stall = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] wen, input logic [1:0] exp_size,
                            input logic [31:0] exp_addr, input string tag);
        sram_en    = 1'b1;
        sram_wen   = wen;
        sram_addr  = 32'h8000_0010;
        sram_wdata = 32'h5566_7788;
        addr_ok    = 1'b1;
        @(negedge clk);
        chk({tag, "_req"},  32'(bus0.req), 32'd1);
        chk({tag, "_wr"},   32'(bus0.wr), 32'd1);
        chk({tag, "_size"}, 32'(bus0.size), 32'(exp_size));
        chk({tag, "_addr"}, bus0.addr, exp_addr);
        chk({tag, "_wdat"}, bus0.wdata, 32'h5566_7788);
        chk({tag, "_err"},  32'(er0), 32'd0);
        step();
        addr_ok = 1'b0;
        data_ok = 1'b1;
        @(negedge clk);
        chk({tag, "_err2"},  32'(er0), 32'd0);
        chk({tag, "_stall"}, 32'(st0), 32'd0);
        step();
        quiet();
    endtask

    int stall_cnt;

    initial begin
        quiet();
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        rst        = 1'b0;

        // Reset gates outputs even with a live request and addr_ok.
        sram_en = 1'b1;
        addr_ok = 1'b1;
        @(negedge clk);
        chk("rst_req",   32'(bus0.req), 32'd0);
        chk("rst_stall", 32'(st0), 32'd0);
        chk("rst_err",   32'(er0), 32'd0);
        chk("rst_rdata", rd0, 32'h0);
        step();
        rst = 1'b1;
        quiet();
        step();

        // Word read, addr_ok with req and data_ok next cycle.
        sram_en   = 1'b1;
        sram_addr = 32'hBFC0_0006;
        addr_ok   = 1'b1;
        @(negedge clk);
        chk("rd_req",   32'(bus0.req), 32'd1);
        chk("rd_wr",    32'(bus0.wr), 32'd0);
        chk("rd_size",  32'(bus0.size), 32'd2);
        chk("rd_addr",  bus0.addr, 32'hBFC0_0004);
        chk("rd_stall", 32'(st0), 32'd1);
        step();
        addr_ok = 1'b0;
        data_ok = 1'b1;
        rdata   = 32'h1234_5678;
        @(negedge clk);
        chk("rd_req2",   32'(bus0.req), 32'd0);
        chk("rd_stall2", 32'(st0), 32'd0);
        chk("rd_data",   rd0, 32'h1234_5678);
        step();
        quiet();
        @(negedge clk);
        chk("rd_hold", rd0, 32'h1234_5678);
        step();

        do_write(4'b0100, 2'd0, 32'h8000_0012, "wb");
        do_write(4'b1100, 2'd1, 32'h8000_0012, "wh");
        do_write(4'b1111, 2'd2, 32'h8000_0010, "ww");

        // Illegal write mask.
        sram_en   = 1'b1;
        sram_wen  = 4'b0101;
        sram_addr = 32'h8000_0013;
        addr_ok   = 1'b1;
        @(negedge clk);
        chk("bad_size", 32'(bus0.size), 32'd2);
        chk("bad_addr", bus0.addr, 32'h8000_0010);
        chk("bad_err",  32'(er0), 32'd1);
        chk("ro_noerr", 32'(er2), 32'd0);
        step();
        addr_ok = 1'b0;
        data_ok = 1'b1;
        @(negedge clk);
        chk("bad_err2", 32'(er0), 32'd0);
        step();
        quiet();
        @(negedge clk);
        chk("bad_err3", 32'(er0), 32'd0);
        step();

        // Delayed handshake, then held result under global stall.
        stall_cnt = 0;
        sram_en   = 1'b1;
        sram_addr = 32'h0000_1000;
        for (int c = 0; c < 11; c++) begin
            addr_ok   = (c == 3);
            data_ok   = (c == 5) || (c == 7);
            rdata     = (c == 5) ? 32'hCAFE_F00D : ((c == 7) ? 32'hDEAD_BEEF : 32'h0);
            all_stall = (c >= 5) && (c <= 9);
            @(negedge clk);
            if (st0) stall_cnt++;
            if (c <= 3) chk($sformatf("dly_req%0d", c), 32'(bus0.req), 32'd1);
            if (c >= 4) chk($sformatf("dly_noreq%0d", c), 32'(bus0.req), 32'd0);
            if (c >= 5) chk($sformatf("dly_data%0d", c), rd0, 32'hCAFE_F00D);
            step();
        end
        chk("dly_stall_cycles", 32'(stall_cnt), 32'd5);
        quiet();
        sram_en = 1'b1;
        @(negedge clk);
        chk("dly_newreq", 32'(bus0.req), 32'd1);
        step();
        quiet();
        step();

        // Flush: sram_en drops while waiting for data_ok.
        sram_en   = 1'b1;
        sram_addr = 32'h0000_2000;
        addr_ok   = 1'b1;
        step();
        quiet();
        @(negedge clk);
        chk("fl_stall", 32'(st0), 32'd0);
        chk("fl_req",   32'(bus0.req), 32'd0);
        step();
        sram_en   = 1'b1;
        sram_addr = 32'h0000_3000;
        @(negedge clk);
        chk("fl_noreq",  32'(bus0.req), 32'd0);
        chk("fl_stall2", 32'(st0), 32'd1);
        step();
        sram_en = 1'b0;
        data_ok = 1'b1;
        rdata   = 32'h1111_2222;
        @(negedge clk);
        chk("fl_stall3", 32'(st0), 32'd0);
        step();
        quiet();
        sram_en = 1'b1;
        @(negedge clk);
        chk("fl_idle_req", 32'(bus0.req), 32'd1);
        chk("fl_hold",     rd0, 32'h1111_2222);
        step();
        quiet();
        step();

        // Reset while a transaction is outstanding.
        sram_en = 1'b1;
        addr_ok = 1'b1;
        step();
        addr_ok = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        chk("mr_req",   32'(bus0.req), 32'd0);
        chk("mr_stall", 32'(st0), 32'd0);
        chk("mr_rdata", rd0, 32'h0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mr_idle_req", 32'(bus0.req), 32'd1);
        chk("mr_hold",     rd0, 32'h0);
        step();
        quiet();
        step();

        // ben-derived read sizing and the read-only port.
        sram_addr = 32'h4000_0003;
        sram_ben  = 4'b0010;
        @(negedge clk);
        chk("ben_size", 32'(bus1.size), 32'd0);
        chk("ben_addr", bus1.addr, 32'h4000_0001);
        chk("full_size", 32'(bus0.size), 32'd2);
        chk("full_addr", bus0.addr, 32'h4000_0000);
        step();
        sram_ben = 4'b1100;
        @(negedge clk);
        chk("ben_hsize", 32'(bus1.size), 32'd1);
        chk("ben_haddr", bus1.addr, 32'h4000_0002);
        step();
        sram_ben = 4'b0000;
        @(negedge clk);
        chk("ben0_size", 32'(bus1.size), 32'd2);
        chk("ben0_addr", bus1.addr, 32'h4000_0000);
        step();
        sram_wen   = 4'b1111;
        sram_wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("ro_wr",    32'(bus2.wr), 32'd0);
        chk("ro_wdata", bus2.wdata, 32'h0);
        chk("rw_wr",    32'(bus0.wr), 32'd1);
        chk("rw_wdata", bus0.wdata, 32'hA5A5_A5A5);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
